// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared constants, FSM encoding and width helper for the FIFO read packer
package fifo_pkg;

  localparam int DATAWIDTH_DEF = 8;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FWAIT = 2'd1,
    ST_FEMIT = 2'd2
  } state_t;

  // Width of a fill counter that must hold every value 0..pack inclusive
  function automatic int fill_cnt_w(input int pack);
    return $clog2(pack + 1);
  endfunction

endpackage

// File: rtl/fifo_rd_packer.sv
// rtl/fifo_rd_packer.sv - drains a FIFO read port and packs PACK entries per wide output word
module fifo_rd_packer
  import fifo_pkg::*;
#(
  parameter int DATAWIDTH = DATAWIDTH_DEF,
  parameter int PACK      = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      f_empty,
  output logic                      rd_en,
  input  logic [DATAWIDTH-1:0]      fifo_data,
  input  logic                      flush,
  output logic                      o_valid,
  input  logic                      o_ready,
  output logic [PACK*DATAWIDTH-1:0] o_data,
  output logic [PACK-1:0]           o_keep,
  output logic                      flush_done
);

  localparam int             CW   = fill_cnt_w(PACK);
  localparam logic [CW-1:0]  FULL = CW'(PACK);

  state_t                    state;
  state_t                    state_nxt;
  logic [PACK*DATAWIDTH-1:0] acc;
  logic [PACK*DATAWIDTH-1:0] part_data;
  logic [PACK-1:0]           part_keep;
  logic [CW-1:0]             cnt;
  logic [CW-1:0]             eff;
  logic [CW:0]               occ;
  logic                      inflight;
  logic                      out_free;
  logic                      move;
  logic                      femit_load;

  // Slot bookkeeping and pop decision: a pop is only issued if its beat is guaranteed a slot
  always_comb begin
    out_free   = !o_valid || o_ready;
    move       = (cnt == FULL) && out_free;
    eff        = move ? '0 : cnt;
    occ        = {1'b0, eff} + {{CW{1'b0}}, inflight};
    rd_en      = !rst && (state == ST_RUN) && !f_empty && (occ < (CW+1)'(PACK));
    femit_load = (state == ST_FEMIT) && (cnt != '0) && out_free;
    flush_done = (state == ST_FEMIT) && ((cnt == '0) || out_free);
  end

  // Partial word for flush: low cnt entries kept, the rest forced to zero
  always_comb begin
    part_keep = ~({PACK{1'b1}} << cnt);
    part_data = '0;
    for (int k = 0; k < PACK; k++) begin
      if (part_keep[k]) begin
        part_data[k*DATAWIDTH +: DATAWIDTH] = acc[k*DATAWIDTH +: DATAWIDTH];
      end
    end
  end

  // Flush FSM next state: stop popping, let the in-flight beat and any full word drain, then emit
  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN:   if (flush) state_nxt = ST_FWAIT;
      ST_FWAIT: if (!inflight && (cnt != FULL)) state_nxt = ST_FEMIT;
      ST_FEMIT: if (flush_done) state_nxt = ST_RUN;
      default:  state_nxt = ST_RUN;
    endcase
  end

  // Flush FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // Fill count, in-flight tracking and output register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      inflight <= 1'b0;
      o_valid  <= 1'b0;
      o_data   <= '0;
      o_keep   <= '0;
    end else begin
      inflight <= rd_en;
      if (inflight) begin
        cnt <= eff + CW'(1);
      end else if (move || femit_load) begin
        cnt <= '0;
      end
      if (move) begin
        o_data  <= acc;
        o_keep  <= '1;
        o_valid <= 1'b1;
      end else if (femit_load) begin
        o_data  <= part_data;
        o_keep  <= part_keep;
        o_valid <= 1'b1;
      end else if (o_ready) begin
        o_valid <= 1'b0;
      end
    end
  end

  // Capture the arriving FIFO beat into the slot chosen by eff
  always_ff @(posedge clk) begin
    if (!rst && inflight) begin
      for (int k = 0; k < PACK; k++) begin
        if (eff == CW'(k)) begin
          acc[k*DATAWIDTH +: DATAWIDTH] <= fifo_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_fifo_rd_packer.sv
// tb/tb_fifo_rd_packer.sv - directed self-checking bench for fifo_rd_packer
module tb_fifo_rd_packer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        f_empty;
  logic        rd_en;
  logic [7:0]  fifo_data = 8'h00;
  logic        flush = 1'b0;
  logic        o_valid;
  logic        o_ready = 1'b1;
  logic [31:0] o_data;
  logic [3:0]  o_keep;
  logic        flush_done;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0]  fmem [0:255];
  int          wr_ptr = 0;
  int          rd_ptr = 0;

  logic [31:0] got_data [$];
  logic [3:0]  got_keep [$];
  logic        rd_hist [$];
  int          fd_cnt = 0;

  fifo_rd_packer #(.DATAWIDTH(8), .PACK(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .f_empty    (f_empty),
    .rd_en      (rd_en),
    .fifo_data  (fifo_data),
    .flush      (flush),
    .o_valid    (o_valid),
    .o_ready    (o_ready),
    .o_data     (o_data),
    .o_keep     (o_keep),
    .flush_done (flush_done)
  );

  always #5 clk = ~clk;

  assign f_empty = (wr_ptr == rd_ptr);

  // FIFO read port model: data appears the cycle after a pop
  always @(posedge clk) begin
    if (rd_en && !f_empty) begin
      fifo_data <= fmem[rd_ptr[7:0]];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  // Output monitor: accepted words, pop history, flush_done pulses
  always @(posedge clk) begin
    if (!rst && o_valid && o_ready) begin
      got_data.push_back(o_data);
      got_keep.push_back(o_keep);
    end
    rd_hist.push_back(rd_en);
    if (!rst && flush_done) fd_cnt <= fd_cnt + 1;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic push(input logic [7:0] v);
    fmem[wr_ptr[7:0]] = v;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic wait_words(input int n, input int budget, output bit ok);
    int c = 0;
    while (got_data.size() < n && c < budget) begin
      @(negedge clk);
      c++;
    end
    ok = (got_data.size() >= n);
  endtask

  task automatic test_reset();
    bit ok;
    int b;
    b = got_data.size();
    for (int i = 1; i <= 4; i++) push(8'hA0 + 8'(i));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_vec++;
      if ({rd_en, o_valid, o_keep, o_data} !== 38'd0) begin
        n_err++;
        $display("FAIL reset_hold[%0d]: got rd_en=%b o_valid=%b o_keep=%h o_data=%h, expected all zero",
                 i, rd_en, o_valid, o_keep, o_data);
      end
    end
    rst = 1'b0;
    #1;
    n_vec++;
    if (rd_en !== 1'b1) begin
      n_err++;
      $display("FAIL reset_release_rd_en: got %b expected 1", rd_en);
    end
    wait_words(b + 1, 30, ok);
    n_vec++;
    if (!ok || got_data[b] !== 32'hA4A3A2A1 || got_keep[b] !== 4'hF) begin
      n_err++;
      $display("FAIL reset_first_word: got ok=%b data=%h keep=%h expected data=a4a3a2a1 keep=f",
               ok, ok ? got_data[b] : 32'h0, ok ? got_keep[b] : 4'h0);
    end
  endtask

  task automatic test_streaming();
    bit ok;
    int b;
    int h;
    logic [8:0] pat;
    b = got_data.size();
    h = rd_hist.size();
    for (int i = 1; i <= 8; i++) push(8'(i));
    wait_words(b + 2, 40, ok);
    n_vec++;
    if (!ok || got_data[b] !== 32'h04030201 || got_keep[b] !== 4'hF) begin
      n_err++;
      $display("FAIL stream_word0: got ok=%b data=%h keep=%h expected 04030201 keep f",
               ok, ok ? got_data[b] : 32'h0, ok ? got_keep[b] : 4'h0);
    end
    n_vec++;
    if (!ok || got_data[b+1] !== 32'h08070605 || got_keep[b+1] !== 4'hF) begin
      n_err++;
      $display("FAIL stream_word1: got ok=%b data=%h keep=%h expected 08070605 keep f",
               ok, ok ? got_data[b+1] : 32'h0, ok ? got_keep[b+1] : 4'h0);
    end
    pat = '0;
    for (int i = 0; i < 9; i++) pat = {pat[7:0], rd_hist[h+i]};
    n_vec++;
    if (pat !== 9'b111101111) begin
      n_err++;
      $display("FAIL stream_rd_en_pattern: got %b expected 111101111", pat);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int b;
    int p0;
    int c;
    b  = got_data.size();
    p0 = rd_ptr;
    for (int i = 1; i <= 12; i++) push(8'(i));
    c = 0;
    while (!o_valid && c < 20) begin
      @(negedge clk);
      c++;
    end
    n_vec++;
    if (o_valid !== 1'b1) begin
      n_err++;
      $display("FAIL bp_first_valid: got o_valid=%b expected 1", o_valid);
    end
    o_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_vec++;
      if (o_valid !== 1'b1 || o_data !== 32'h04030201) begin
        n_err++;
        $display("FAIL bp_hold[%0d]: got o_valid=%b o_data=%h expected 1 04030201", i, o_valid, o_data);
      end
    end
    n_vec++;
    if (rd_ptr - p0 !== 8) begin
      n_err++;
      $display("FAIL bp_pop_count: got %0d expected 8", rd_ptr - p0);
    end
    n_vec++;
    if (got_data.size() !== b) begin
      n_err++;
      $display("FAIL bp_no_accept: got %0d words expected %0d", got_data.size(), b);
    end
    o_ready = 1'b1;
    wait_words(b + 3, 40, ok);
    n_vec++;
    if (!ok || got_data[b] !== 32'h04030201 || got_data[b+1] !== 32'h08070605 ||
        got_data[b+2] !== 32'h0C0B0A09) begin
      n_err++;
      $display("FAIL bp_release_order: got ok=%b %h %h %h expected 04030201 08070605 0c0b0a09",
               ok, ok ? got_data[b] : 32'h0, ok ? got_data[b+1] : 32'h0, ok ? got_data[b+2] : 32'h0);
    end
  endtask

  task automatic test_flush_partial();
    bit ok;
    int b;
    int f0;
    b = got_data.size();
    for (int i = 1; i <= 6; i++) push(8'(i));
    wait_words(b + 1, 30, ok);
    repeat (4) @(negedge clk);
    n_vec++;
    if (got_data.size() !== b + 1 || got_data[b] !== 32'h04030201) begin
      n_err++;
      $display("FAIL fp_full_word: got %0d words first=%h expected %0d words first=04030201",
               got_data.size(), got_data.size() > b ? got_data[b] : 32'h0, b + 1);
    end
    f0 = fd_cnt;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    for (int i = 0; i < 4; i++) push(8'h11 + 8'(i));
    n_vec++;
    if (flush_done !== 1'b0 || rd_en !== 1'b0) begin
      n_err++;
      $display("FAIL fp_fwait: got flush_done=%b rd_en=%b expected 0 0", flush_done, rd_en);
    end
    @(negedge clk);
    n_vec++;
    if (flush_done !== 1'b1) begin
      n_err++;
      $display("FAIL fp_done_pulse: got %b expected 1", flush_done);
    end
    @(negedge clk);
    n_vec++;
    if (rd_en !== 1'b1 || o_valid !== 1'b1 || o_data !== 32'h00000605 || o_keep !== 4'h3) begin
      n_err++;
      $display("FAIL fp_partial_out: got rd_en=%b o_valid=%b o_data=%h o_keep=%h expected 1 1 00000605 3",
               rd_en, o_valid, o_data, o_keep);
    end
    wait_words(b + 3, 30, ok);
    n_vec++;
    if (!ok || got_data[b+1] !== 32'h00000605 || got_keep[b+1] !== 4'h3 ||
        got_data[b+2] !== 32'h14131211 || got_keep[b+2] !== 4'hF) begin
      n_err++;
      $display("FAIL fp_word_seq: got ok=%b %h/%h %h/%h expected 00000605/3 14131211/f",
               ok, ok ? got_data[b+1] : 32'h0, ok ? got_keep[b+1] : 4'h0,
               ok ? got_data[b+2] : 32'h0, ok ? got_keep[b+2] : 4'h0);
    end
    n_vec++;
    if (fd_cnt - f0 !== 1) begin
      n_err++;
      $display("FAIL fp_done_count: got %0d expected 1", fd_cnt - f0);
    end
  endtask

  task automatic test_flush_empty();
    int f0;
    f0 = fd_cnt;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    n_vec++;
    if (flush_done !== 1'b0 || o_valid !== 1'b0) begin
      n_err++;
      $display("FAIL fe_cycle1: got flush_done=%b o_valid=%b expected 0 0", flush_done, o_valid);
    end
    @(negedge clk);
    n_vec++;
    if (flush_done !== 1'b1 || o_valid !== 1'b0) begin
      n_err++;
      $display("FAIL fe_cycle2: got flush_done=%b o_valid=%b expected 1 0", flush_done, o_valid);
    end
    @(negedge clk);
    n_vec++;
    if (flush_done !== 1'b0 || o_valid !== 1'b0 || fd_cnt - f0 !== 1) begin
      n_err++;
      $display("FAIL fe_cycle3: got flush_done=%b o_valid=%b pulses=%0d expected 0 0 1",
               flush_done, o_valid, fd_cnt - f0);
    end
  endtask

  task automatic test_flush_midpop();
    bit ok;
    int b;
    b = got_data.size();
    push(8'h21);
    flush = 1'b1;
    #1;
    n_vec++;
    if (rd_en !== 1'b1) begin
      n_err++;
      $display("FAIL fm_rd_en_in_flush: got %b expected 1", rd_en);
    end
    @(negedge clk);
    flush = 1'b0;
    wait_words(b + 1, 20, ok);
    n_vec++;
    if (!ok || got_data[b] !== 32'h00000021 || got_keep[b] !== 4'h1) begin
      n_err++;
      $display("FAIL fm_partial_word: got ok=%b data=%h keep=%h expected 00000021 keep 1",
               ok, ok ? got_data[b] : 32'h0, ok ? got_keep[b] : 4'h0);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int b;
    b = got_data.size();
    for (int i = 1; i <= 3; i++) push(8'h30 + 8'(i));
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    n_vec++;
    if (got_data.size() !== b || o_valid !== 1'b0) begin
      n_err++;
      $display("FAIL rm_no_output: got %0d words o_valid=%b expected %0d words o_valid=0",
               got_data.size(), o_valid, b);
    end
    for (int i = 1; i <= 4; i++) push(8'h40 + 8'(i));
    wait_words(b + 1, 20, ok);
    repeat (6) @(negedge clk);
    n_vec++;
    if (!ok || got_data.size() !== b + 1 || got_data[b] !== 32'h44434241 || got_keep[b] !== 4'hF) begin
      n_err++;
      $display("FAIL rm_clean_word: got ok=%b words=%0d data=%h keep=%h expected 1 word 44434241 keep f",
               ok, got_data.size() - b, ok ? got_data[b] : 32'h0, ok ? got_keep[b] : 4'h0);
    end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush_partial();
    test_flush_empty();
    test_flush_midpop();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
